// File: rtl/riscv_hazard_unit.sv
// rtl/riscv_hazard_unit.sv - pipeline hazard detection, forwarding select and event counters
module riscv_hazard_unit (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [4:0]  i_ID_rs1_addr,
  input  logic [4:0]  i_ID_rs2_addr,
  input  logic [4:0]  i_EX_rs1_addr,
  input  logic [4:0]  i_EX_rs2_addr,
  input  logic [4:0]  i_EX_rd_addr,
  input  logic        i_EX_mem_read,
  input  logic        i_EX_pc_src,
  input  logic [4:0]  i_MEM_rd_addr,
  input  logic        i_MEM_reg_write,
  input  logic [4:0]  i_WB_rd_addr,
  input  logic        i_WB_reg_write,
  input  logic        i_cnt_clr,
  output logic        o_StallF,
  output logic        o_StallD,
  output logic        o_FlushD,
  output logic        o_FlushE,
  output logic [1:0]  o_ForwardAE,
  output logic [1:0]  o_ForwardBE,
  output logic [1:0]  o_state,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        lu;
  logic        stall_ev;
  logic        mem_wr_ok;
  logic        wb_wr_ok;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  assign lu = i_EX_mem_read && (i_EX_rd_addr != 5'd0) &&
              ((i_EX_rd_addr == i_ID_rs1_addr) || (i_EX_rd_addr == i_ID_rs2_addr));

  // A taken branch squashes the dependent instruction, so it overrides the stall.
  assign stall_ev = lu && !i_EX_pc_src;

  assign mem_wr_ok = i_MEM_reg_write && (i_MEM_rd_addr != 5'd0);
  assign wb_wr_ok  = i_WB_reg_write && (i_WB_rd_addr != 5'd0);

  always_comb begin
    o_StallF    = 1'b0;
    o_StallD    = 1'b0;
    o_FlushD    = 1'b1;
    o_FlushE    = 1'b1;
    o_ForwardAE = 2'b00;
    o_ForwardBE = 2'b00;
    if (i_rstn) begin
      o_StallF = stall_ev;
      o_StallD = stall_ev;
      o_FlushD = i_EX_pc_src;
      o_FlushE = i_EX_pc_src || lu;
      if (mem_wr_ok && (i_MEM_rd_addr == i_EX_rs1_addr))
        o_ForwardAE = 2'b10;
      else if (wb_wr_ok && (i_WB_rd_addr == i_EX_rs1_addr))
        o_ForwardAE = 2'b01;
      if (mem_wr_ok && (i_MEM_rd_addr == i_EX_rs2_addr))
        o_ForwardBE = 2'b10;
      else if (wb_wr_ok && (i_WB_rd_addr == i_EX_rs2_addr))
        o_ForwardBE = 2'b01;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (i_EX_pc_src)
      state_d = ST_FLUSH;
    else if (lu)
      state_d = ST_STALL;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else if (i_cnt_clr) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_ev && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (i_EX_pc_src && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign o_state     = state_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: doc/riscv_hazard_unit.md
RISCV_HAZARD_UNIT -- requirements
Module: riscv_hazard_unit

Interface
REQ-001 Parameter: none; register-address width SHALL be fixed at 5 bits, counter width at 16 bits.
REQ-002 Port order SHALL be i_clk first, then i_rstn; one clock; reset SHALL be asynchronous, active-low.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rstn  input  1  asynchronous active-low reset.
REQ-005 i_ID_rs1_addr, i_ID_rs2_addr  input  5  source registers of the instruction in ID.
REQ-006 i_EX_rs1_addr, i_EX_rs2_addr  input  5  source registers held in the ID/EX register.
REQ-007 i_EX_rd_addr  input  5  destination register in EX; i_EX_mem_read  input  1  EX instruction is a load.
REQ-008 i_EX_pc_src  input  1  taken branch or jump resolved in EX.
REQ-009 i_MEM_rd_addr  input  5; i_MEM_reg_write  input  1  destination and write enable in MEM.
REQ-010 i_WB_rd_addr  input  5; i_WB_reg_write  input  1  destination and write enable in WB.
REQ-011 i_cnt_clr  input  1  synchronous clear of both event counters.
REQ-012 o_StallF, o_StallD  output  1  hold PC and IF/ID register.
REQ-013 o_FlushD, o_FlushE  output  1  bubble IF/ID and ID/EX registers; o_FlushE drives the ID/EX i_FlushE input.
REQ-014 o_ForwardAE, o_ForwardBE  output  2  EX operand select: 00 register file, 01 WB result, 10 MEM result.
REQ-015 o_state  output  2  registered last-cycle action: 00 RUN, 01 STALL, 10 FLUSH; 11 never produced.
REQ-016 o_stall_cnt, o_flush_cnt  output  16  saturating event counters.

Function
REQ-017 Load-use hazard lu SHALL be i_EX_mem_read & (i_EX_rd_addr != 0) & (i_EX_rd_addr == i_ID_rs1_addr | i_EX_rd_addr == i_ID_rs2_addr).
REQ-018 With lu=1 and i_EX_pc_src=0: o_StallF=1, o_StallD=1, o_FlushE=1, o_FlushD=0, same cycle (combinational, zero latency).
REQ-019 With i_EX_pc_src=1: o_FlushD=1, o_FlushE=1, o_StallF=0, o_StallD=0, regardless of lu (branch wins on simultaneous events).
REQ-020 Neither event: all four stall/flush outputs 0.
REQ-021 o_ForwardAE SHALL be 10 if i_MEM_reg_write & i_MEM_rd_addr!=0 & i_MEM_rd_addr==i_EX_rs1_addr; else 01 if the same holds for WB; else 00; MEM takes priority over WB.
REQ-022 o_ForwardBE SHALL use the same rule against i_EX_rs2_addr.
REQ-023 Register x0 SHALL never cause a stall or forward.
REQ-024 State register SHALL load on each rising edge: FLUSH if i_EX_pc_src, else STALL if lu, else RUN; o_state is that register (one-cycle latency).
REQ-025 o_stall_cnt SHALL increment by 1 on each edge where o_StallD=1; o_flush_cnt on each edge where i_EX_pc_src=1.
REQ-026 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-027 i_cnt_clr=1 SHALL zero both counters on the edge, overriding any same-cycle increment; state register unaffected.

Reset
REQ-028 While i_rstn=0: o_state=00, o_stall_cnt=0, o_flush_cnt=0 immediately (asynchronous).
REQ-029 While i_rstn=0: o_StallF=o_StallD=0, o_FlushD=o_FlushE=1, o_ForwardAE=o_ForwardBE=00, independent of other inputs.
REQ-030 Reset asserted mid-stall SHALL abort the stall; first edge after release evaluates inputs normally.

Verification
REQ-031 Load-use: EX_mem_read=1, EX_rd=5, ID_rs2=5, pc_src=0 -> StallF=StallD=FlushE=1, FlushD=0; next edge o_state=01, o_stall_cnt=1.
REQ-032 Branch vs load-use: same as REQ-031 plus pc_src=1 -> FlushD=FlushE=1, StallF=StallD=0; o_state=10, o_flush_cnt=1, o_stall_cnt unchanged.
REQ-033 Forward priority: MEM_rd=WB_rd=EX_rs1=7, both write=1 -> ForwardAE=10; MEM_reg_write=0 -> 01; all rd=0 with writes=1 -> 00.
REQ-034 x0: EX_mem_read=1, EX_rd=0, ID_rs1=0 -> no stall; o_state stays 00.
REQ-035 Saturation/clear: hold lu 65540 cycles -> o_stall_cnt=16'hFFFF; assert i_cnt_clr with lu=1 -> 0 next edge, then 1 the edge after.
REQ-036 Async reset: drop i_rstn mid-cycle during lu -> outputs per REQ-028/029 before next edge; release -> RUN.
